// File: rtl/pin_uart_bank_if.sv
// Pin-identification UART bank bus: run enable in, UART lines and status out.
interface pin_uart_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  logic                en;
  logic [CHANNELS-1:0] out;
  logic                busy;
  logic                frame_done;
  logic [15:0]         frame_cnt;

  modport master (output en, input out, busy, frame_done, frame_cnt);
  modport slave  (input en, output out, busy, frame_done, frame_cnt);
endinterface

// File: rtl/pin_uart_bank.sv
// Multi-channel pin-identification transmitter: every pin repeatedly sends its
// own name as 8N1 UART, sharing one baud counter and one slot sequencer.
module pin_uart_bank #(
  parameter int unsigned                     CHANNELS    = 8,
  parameter int unsigned                     MAX_CHARS   = 4,
  parameter logic [CHANNELS*MAX_CHARS*8-1:0] NAMES       = '0,
  parameter int unsigned                     BAUD_DIV    = 16,
  parameter int unsigned                     GAP_BITS    = 20,
  parameter int unsigned                     MODE        = 0,
  parameter int unsigned                     APPEND_CRLF = 1
) (
  input  logic           clk,
  input  logic           rst,
  pin_uart_bank_if.slave bus
);

  localparam int unsigned SLOTS  = MAX_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned BIT_W  = (GAP_W > 3) ? GAP_W : 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud;
  logic [BIT_W-1:0]   bit_idx;
  logic [SLOT_W-1:0]  slot;
  logic [CH_W-1:0]    ch;

  // Character carried by channel c in slot s: name bytes MSB-first, then CR, LF.
  function automatic logic [7:0] slot_char(input int unsigned c, input int unsigned s);
    if (s < MAX_CHARS) return NAMES[(c*MAX_CHARS + (MAX_CHARS - 1 - s))*8 +: 8];
    else if (s == MAX_CHARS) return 8'h0D;
    else return 8'h0A;
  endfunction

  // Line levels for a start bit or data bit b; NUL slots and inactive lanes idle high.
  function automatic logic [CHANNELS-1:0] line_bits(input logic              is_start,
                                                    input logic [SLOT_W-1:0] s,
                                                    input logic [2:0]        b,
                                                    input logic [CH_W-1:0]   k);
    logic [CHANNELS-1:0] l;
    logic [7:0]          chr;
    l = '1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chr = slot_char(c, 32'(s));
      if (((MODE == 0) || (c == 32'(k))) && (chr != 8'h00))
        l[CH_W'(c)] = is_start ? 1'b0 : chr[b];
    end
    return l;
  endfunction

  // Next active channel; only round-robin mode moves it.
  function automatic logic [CH_W-1:0] ch_succ(input logic [CH_W-1:0] k);
    if (MODE == 0) return k;
    else if (k == CH_W'(CHANNELS - 1)) return '0;
    else return k + CH_W'(1);
  endfunction

  // Sequencer: bit timing, slot/channel stepping and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      baud           <= '0;
      bit_idx        <= '0;
      slot           <= '0;
      ch             <= '0;
      bus.out        <= '1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_cnt  <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.en) begin
          state    <= S_START;
          baud     <= '0;
          bit_idx  <= '0;
          slot     <= '0;
          bus.busy <= 1'b1;
          bus.out  <= line_bits(1'b1, SLOT_W'(0), 3'd0, ch);
        end
      end else if (baud != BAUD_W'(BAUD_DIV - 1)) begin
        baud <= baud + BAUD_W'(1);
      end else begin
        baud <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
            bus.out <= line_bits(1'b0, slot, 3'd0, ch);
          end
          S_DATA: begin
            if (bit_idx[2:0] == 3'd7) begin
              state   <= S_STOP;
              bus.out <= '1;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              bus.out <= line_bits(1'b0, slot, 3'(bit_idx[2:0] + 3'd1), ch);
            end
          end
          S_STOP: begin
            bus.out <= '1;
            if (slot == SLOT_W'(SLOTS - 1)) begin
              // A completed message always counts, whatever en is doing.
              state          <= S_GAP;
              bit_idx        <= '0;
              bus.frame_done <= 1'b1;
              bus.frame_cnt  <= bus.frame_cnt + 16'd1;
            end else if (!bus.en) begin
              state    <= S_IDLE;
              slot     <= '0;
              bus.busy <= 1'b0;
            end else begin
              state   <= S_START;
              slot    <= slot + SLOT_W'(1);
              bus.out <= line_bits(1'b1, slot + SLOT_W'(1), 3'd0, ch);
            end
          end
          S_GAP: begin
            if (bit_idx == BIT_W'(GAP_BITS - 1)) begin
              ch <= ch_succ(ch);
              if (bus.en) begin
                state   <= S_START;
                slot    <= '0;
                bit_idx <= '0;
                bus.out <= line_bits(1'b1, SLOT_W'(0), 3'd0, ch_succ(ch));
              end else begin
                state    <= S_IDLE;
                slot     <= '0;
                bus.busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
          default: begin
            state    <= S_IDLE;
            bus.out  <= '1;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_uart_bank.sv
// Bench for pin_uart_bank: per-cycle expected line/status stream built from the
// message rules, checked by an independent monitor.
module tb_pin_uart_bank;

  localparam int unsigned CHN = 2;

  logic clk;
  logic rst;

  pin_uart_bank_if #(.CHANNELS(CHN)) if_a ();
  pin_uart_bank_if #(.CHANNELS(CHN)) if_b ();
  pin_uart_bank_if #(.CHANNELS(CHN)) if_c ();

  // Channel 0 = "A1", channel 1 = "B" + NUL.
  pin_uart_bank #(
    .CHANNELS(CHN), .MAX_CHARS(2), .NAMES(32'h4200_4131), .BAUD_DIV(4),
    .GAP_BITS(2), .MODE(0), .APPEND_CRLF(1)
  ) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  pin_uart_bank #(
    .CHANNELS(CHN), .MAX_CHARS(2), .NAMES(32'h4200_4131), .BAUD_DIV(4),
    .GAP_BITS(2), .MODE(1), .APPEND_CRLF(1)
  ) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  pin_uart_bank #(
    .CHANNELS(CHN), .MAX_CHARS(2), .NAMES(32'h4200_4131), .BAUD_DIV(2),
    .GAP_BITS(1), .MODE(0), .APPEND_CRLF(0)
  ) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct packed {
    logic [1:0]  o;
    logic        busy;
    logic        fd;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  bit          mon_hold = 0;
  logic [15:0] mcnt [3];
  int          mch = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string tag_name(input int t);
    case (t)
      1: return "mode0_run";
      2: return "stop_mid";
      3: return "rr_run";
      4: return "reset_restart";
      5: return "wrap_nocrlf";
      default: return "unknown";
    endcase
  endfunction

  // Reference configuration of the three instances.
  function automatic int baud_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction
  function automatic int gap_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int nslots(input int d);
    return (d == 2) ? 2 : 4;
  endfunction

  // Character in slot s of channel c's message.
  function automatic logic [7:0] char_of(input int c, input int s);
    if (s == 0) return (c == 0) ? 8'h41 : 8'h42;
    if (s == 1) return (c == 0) ? 8'h31 : 8'h00;
    if (s == 2) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic push(input logic [1:0] o, input logic busy, input logic fd,
                      input logic [15:0] cnt, input int tag);
    exp_t e;
    e.o = o; e.busy = busy; e.fd = fd; e.cnt = cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Slots 0..last_slot of one message; channel k alone transmits in round-robin.
  task automatic push_msg(input int d, input int k, input int last_slot, input int tag);
    logic [1:0] o;
    logic [7:0] b;
    logic       v;
    for (int s = 0; s <= last_slot; s++) begin
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < 2; c++) begin
          b = char_of(c, s);
          if (i == 0) v = 1'b0;
          else if (i == 9) v = 1'b1;
          else v = b[i-1];
          o[c] = (b != 8'h00 && (d != 1 || c == k)) ? v : 1'b1;
        end
        repeat (baud_of(d)) push(o, 1'b1, 1'b0, mcnt[d], tag);
      end
    end
  endtask

  task automatic push_gap(input int d, input int tag);
    mcnt[d] = mcnt[d] + 16'd1;
    for (int j = 0; j < gap_of(d) * baud_of(d); j++)
      push(2'b11, 1'b1, (j == 0), mcnt[d], tag);
    if (d == 1) mch = (mch + 1) % 2;
  endtask

  task automatic push_idle(input int d, input int n, input int tag);
    repeat (n) push(2'b11, 1'b0, 1'b0, mcnt[d], tag);
  endtask

  task automatic set_en(input int d, input logic v);
    case (d)
      0: if_a.en = v;
      1: if_b.en = v;
      default: if_c.en = v;
    endcase
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int limit, input int tag);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s drain: %0d expected cycles pending after %0d cycles",
               tag_name(tag), exp_q.size(), limit);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // n back-to-back messages with en held, en dropped somewhere in the final gap.
  task automatic run_msgs(input int d, input int n, input int tag);
    int len, g, drop, gl;
    @(negedge clk);
    sel = d;
    len = nslots(d) * 10 * baud_of(d);
    gl  = gap_of(d) * baud_of(d);
    for (int m = 0; m < n; m++) begin
      push_msg(d, (d == 1) ? mch : 0, nslots(d) - 1, tag);
      push_gap(d, tag);
    end
    push_idle(d, 4, tag);
    g    = n * len + (n - 1) * gl;
    drop = g + int'($urandom_range(gl - 1, 0));
    set_en(d, 1'b1);
    repeat (drop + 1) @(negedge clk);
    set_en(d, 1'b0);
    wait_drain(5000, tag);
  endtask

  // en dropped at cycle off inside slot s: the slot finishes, then idle.
  task automatic stop_mid(input int s, input int off);
    @(negedge clk);
    sel = 0;
    push_msg(0, 0, s, 2);
    push_idle(0, 6, 2);
    if_a.en = 1'b1;
    repeat (s * 40 + off + 1) @(negedge clk);
    if_a.en = 1'b0;
    wait_drain(1000, 2);
  endtask

  // Monitor: compare every cycle against the next expected entry.
  initial begin
    exp_t act;
    exp_t e;
    int   t;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_hold && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        case (sel)
          0: act = {if_a.out, if_a.busy, if_a.frame_done, if_a.frame_cnt};
          1: act = {if_b.out, if_b.busy, if_b.frame_done, if_b.frame_cnt};
          default: act = {if_c.out, if_c.busy, if_c.frame_done, if_c.frame_cnt};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s cycle: got out=%b busy=%b fd=%b cnt=%h, expected out=%b busy=%b fd=%b cnt=%h",
                   tag_name(t), act.o, act.busy, act.fd, act.cnt, e.o, e.busy, e.fd, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, e;
    rst = 1'b1;
    if_a.en = 1'b0;
    if_b.en = 1'b0;
    if_c.en = 1'b0;
    for (int d = 0; d < 3; d++) mcnt[d] = 16'h0000;
    #1 rst = 1'b0;
    #2;
    check("reset_out_a", 16'(if_a.out), 16'h0003);
    check("reset_busy_a", 16'(if_a.busy), 16'h0000);
    check("reset_fd_a", 16'(if_a.frame_done), 16'h0000);
    check("reset_cnt_a", if_a.frame_cnt, 16'h0000);
    check("reset_out_b", 16'(if_b.out), 16'h0003);
    check("reset_out_c", 16'(if_c.out), 16'h0003);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_msgs(0, int'($urandom_range(3, 2)), 1);

    stop_mid(1, 12);
    stop_mid(int'($urandom_range(2, 0)), int'($urandom_range(39, 0)));
    check("stop_cnt_a", if_a.frame_cnt, mcnt[0]);

    run_msgs(1, int'($urandom_range(4, 3)), 3);
    check("rr_cnt_b", if_b.frame_cnt, mcnt[1]);

    // Async reset in a data bit that drives the active line low.
    @(negedge clk);
    sel = 1;
    k = mch;
    push_msg(1, k, 3, 4);
    if_b.en = 1'b1;
    e = (k == 0) ? 9 : 5;
    repeat (e + 1) @(negedge clk);
    mon_hold = 1'b1;
    exp_q.delete();
    tag_q.delete();
    if_b.en = 1'b0;
    check("pre_rst_line", 16'(if_b.out), (k == 0) ? 16'h0002 : 16'h0001);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", 16'(if_b.out), 16'h0003);
    check("async_rst_busy", 16'(if_b.busy), 16'h0000);
    check("async_rst_cnt", if_b.frame_cnt, 16'h0000);
    for (int d = 0; d < 3; d++) mcnt[d] = 16'h0000;
    mch = 0;
    @(negedge clk);
    rst = 1'b1;
    mon_hold = 1'b0;
    run_msgs(1, 1, 4);

    // Counter wrap on the no-CRLF instance.
    @(negedge clk);
    force if_c.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release if_c.frame_cnt;
    #1;
    check("wrap_preload", if_c.frame_cnt, 16'hFFFF);
    mcnt[2] = 16'hFFFF;
    run_msgs(2, 1, 5);
    check("wrap_cnt", if_c.frame_cnt, 16'h0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_uart_bank.md
Name: pin_uart_bank

Overview:
- Parametrised multi-channel pin-identification transmitter. Each output pin repeatedly sends its own name string as 8N1 UART, so a probe on any pin shows which pin it is.
- Replaces one-instance-per-pin identification with one bank that shares a single baud generator and message sequencer across all channels.
- Adds a selectable mode: all channels transmit together, or channels take turns (round-robin).
- Sits directly under the board top level and is clocked from the divided internal oscillator.

Parameters:
- CHANNELS, 8, number of output pins driven (1..64).
- MAX_CHARS, 4, character slots per name.
- NAMES, all-zero, packed ASCII of CHANNELS*MAX_CHARS*8 bits. Channel c occupies bits [c*MAX_CHARS*8 +: MAX_CHARS*8], first character in the most significant byte, NUL-padded at the end.
- BAUD_DIV, 16, clk cycles per UART bit (>=2).
- GAP_BITS, 20, idle-high bit times between messages (>=1).
- MODE, 0, 0 = all channels transmit simultaneously; 1 = round-robin, one channel at a time.
- APPEND_CRLF, 1, 1 = append 0x0D and 0x0A slots after the name.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- out  out  CHANNELS  UART lines; idle high.
- busy  out  1  high while any character or gap is in progress.
- frame_done  out  1  one-cycle pulse at the end of each message's final stop bit.
- frame_cnt  out  16  count of completed messages; wraps modulo 2^16.

Behaviour:
- Reset (rst=0, asynchronous): out = all 1s, busy=0, frame_done=0, frame_cnt=0, state IDLE, baud/bit/slot/channel counters = 0.
- Baud tick: counter 0..BAUD_DIV-1.
  - Cleared on entry to START from IDLE.
  - Runs in every state except IDLE.
  - Each bit is held exactly BAUD_DIV cycles.
- Slot sequence per message: slots 0..MAX_CHARS-1 carry name characters. If APPEND_CRLF=1, slot MAX_CHARS carries CR (0x0D) and slot MAX_CHARS+1 carries LF (0x0A).
- Each slot is 10 bit times: start (0), 8 data bits LSB first, stop (1).
- A NUL character in a slot: that channel's line stays high for the full 10 bit times (no start bit). Other channels are unaffected.
- A name that is entirely NUL produces only CRLF, or an all-idle message if APPEND_CRLF=0.
- States:
  - IDLE: all out high, busy=0. Leaves when en=1 (sampled on a clk edge); the start bit appears on out in the next cycle (registered output, latency 1).
  - START: 1 bit time.
  - DATA: 8 bit times.
  - STOP: 1 bit time.
    - After STOP with more slots remaining: START of the next slot.
    - After STOP of the last slot: pulse frame_done, increment frame_cnt, go to GAP.
  - GAP: GAP_BITS bit times, all lines high, busy=1.
    - At the end of GAP with en=1: start a new message (START, slot 0).
    - At the end of GAP with en=0: go to IDLE.
- MODE 0: every channel drives its own slot data in lockstep. One message equals one frame_done.
- MODE 1:
  - Only channel ch (active index) drives; all other outs stay high.
  - ch advances 0..CHANNELS-1 after each GAP and wraps to 0.
  - frame_done fires once per channel message.
  - When leaving IDLE, ch resumes from its held value (not reset).
- en deasserted mid-message: the current slot completes through its stop bit, then the block goes directly to IDLE. No frame_done, no frame_cnt increment, GAP skipped.
- en re-asserted in the same cycle a slot ends: the message continues; no glitch on out.
- en deasserted during GAP: the gap completes, then IDLE.
- Reset asserted mid-character: all outs go high immediately (asynchronous). After release, the block restarts from IDLE with slot 0 and ch=0.
- frame_cnt 0xFFFF plus one completion wraps to 0x0000. frame_done still pulses.
- No combinational path from en to out; all outputs are registered.

Test Plan:
- Single name, MODE 0:
  - Setup: CHANNELS=2, MAX_CHARS=2, NAMES={"A1","B\0"}, BAUD_DIV=4, GAP_BITS=2, APPEND_CRLF=1, en=1 after reset.
  - out[0] must carry 0x41,0x31,0x0D,0x0A, each bit 4 cycles, first start bit 1 cycle after en.
  - out[1] must carry 0x42, then 40 idle-high cycles, then 0x0D,0x0A.
  - frame_done pulses at cycle 160 after the start bit; then an 8-cycle gap.
- Round-robin, MODE 1, same names:
  - Only out[0] toggles for the first message, only out[1] for the second, then out[0] again.
  - frame_cnt reads 3 after three messages.
- Stop mid-message: drop en during bit 3 of slot 1.
  - Slot 1 completes with its stop bit; busy falls 1 cycle later.
  - No frame_done; frame_cnt unchanged; all outs stay high afterwards.
- Async reset during a data bit: assert rst=0 between clock edges.
  - out goes to all 1s without waiting for a clk edge.
  - After release with en=1, slot 0 restarts on ch 0.
- Wrap and no-CRLF check:
  - Preload frame_cnt to 0xFFFF via a forced run, then complete one message.
  - frame_cnt reads 0x0000 and frame_done pulses.
  - With APPEND_CRLF=0, the message length is exactly MAX_CHARS*10 bit times.
